// File: rtl/umi_resp_watchdog.sv
// ----------------------------------------------------------------------------
// umi_resp_watchdog
//
// Sits between the core host port and the crossbar device-side inputs. Lets
// one core request out at a time and passes its response back. If the
// crossbar does not answer within TIMEOUT cycles, a locally built error
// response is returned instead, so the core never hangs on a dead address.
//
// Ports
//   clk, nreset                 clock, asynchronous active-low reset
//   udev_req_*   (in)  / udev_req_ready   (out)  request from core
//   udev_resp_*  (out) / udev_resp_ready  (in)   response to core
//   uhost_req_*  (out) / uhost_req_ready  (in)   request to crossbar
//   uhost_resp_* (in)  / uhost_resp_ready (out)  response from crossbar
//   timeout_pulse  (out)  one-cycle strobe, high in the first ERR cycle
//   timeout_count  (out)  saturating count of timeouts
//
// Build option
//   UMI_WATCHDOG_COUNT_EN  when defined, timeout_count counts timeouts;
//                          otherwise it is tied to 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | request path open, next request forwarded combinationally
// WAIT  | request outstanding, response path open, timer running
// ERR   | presenting the local error response to the core
// DRAIN | swallowing a late crossbar response, timer running
// ----------------------------------------------------------------------------
module umi_resp_watchdog #(
    parameter int DW      = 32,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready,
    output logic          timeout_pulse,
    output logic [15:0]   timeout_count
);

    localparam int              CNTW     = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [4:0]      OP_RD    = 5'h01;
    localparam logic [4:0]      OP_POST  = 5'h05;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic [4:0]      r_op;
    logic [10:0]     r_szlen;
    logic [4:0]      r_hostid;
    logic [AW-1:0]   r_dst;
    logic [AW-1:0]   r_src;
    logic            r_pulse;
    logic            w_req_hs;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_timeout;
    logic [CW-1:0]   w_err_cmd;

    // Request payload always flows through; only valid/ready are gated.
    assign uhost_req_cmd     = udev_req_cmd;
    assign uhost_req_dstaddr = udev_req_dstaddr;
    assign uhost_req_srcaddr = udev_req_srcaddr;
    assign uhost_req_data    = udev_req_data;

    assign w_req_hs = (r_state == S_IDLE) && udev_req_valid && uhost_req_ready;

    // Error response is built from registered fields only, so it is stable
    // for as long as the core stalls it.
    always_comb begin
        w_err_cmd        = '0;
        w_err_cmd[4:0]   = (r_op == OP_RD) ? 5'h02 : 5'h04;
        w_err_cmd[15:5]  = r_szlen;
        w_err_cmd[22]    = 1'b1;
        w_err_cmd[26:25] = 2'b10;
        w_err_cmd[31:27] = r_hostid;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_szlen  <= '0;
            r_hostid <= '0;
            r_dst    <= '0;
            r_src    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pulse <= w_timeout;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_req_hs) begin
                r_op     <= udev_req_cmd[4:0];
                r_szlen  <= udev_req_cmd[15:5];
                r_hostid <= udev_req_cmd[31:27];
                r_dst    <= udev_req_dstaddr;
                r_src    <= udev_req_srcaddr;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        w_cnt_clr         = 1'b0;
        w_cnt_inc         = 1'b0;
        w_timeout         = 1'b0;
        uhost_req_valid   = 1'b0;
        udev_req_ready    = 1'b0;
        udev_resp_valid   = 1'b0;
        uhost_resp_ready  = 1'b0;
        udev_resp_cmd     = uhost_resp_cmd;
        udev_resp_dstaddr = uhost_resp_dstaddr;
        udev_resp_srcaddr = uhost_resp_srcaddr;
        udev_resp_data    = uhost_resp_data;
        case (r_state)
            S_IDLE: begin
                uhost_req_valid = udev_req_valid;
                udev_req_ready  = uhost_req_ready;
                if (w_req_hs) begin
                    w_cnt_clr = 1'b1;
                    if (udev_req_cmd[4:0] != OP_POST) begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                udev_resp_valid  = uhost_resp_valid;
                uhost_resp_ready = udev_resp_ready;
                // A handshake in the expiry cycle takes priority over timeout.
                if (uhost_resp_valid && udev_resp_ready) begin
                    if (uhost_resp_cmd[22]) begin
                        w_next = S_IDLE;
                    end else begin
                        w_cnt_clr = 1'b1;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_next    = S_ERR;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_ERR: begin
                udev_resp_valid   = 1'b1;
                udev_resp_cmd     = w_err_cmd;
                udev_resp_dstaddr = r_src;
                udev_resp_srcaddr = r_dst;
                udev_resp_data    = '0;
                if (udev_resp_ready) begin
                    w_next    = S_DRAIN;
                    w_cnt_clr = 1'b1;
                end
            end
            S_DRAIN: begin
                uhost_resp_ready = 1'b1;
                if ((uhost_resp_valid && uhost_resp_cmd[22]) || (r_cnt == CNT_LAST)) begin
                    w_next = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign timeout_pulse = r_pulse;

`ifdef UMI_WATCHDOG_COUNT_EN
    logic [15:0] r_tcount;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_tcount <= '0;
        end else if (w_timeout && (r_tcount != 16'hFFFF)) begin
            r_tcount <= r_tcount + 16'd1;
        end
    end

    assign timeout_count = r_tcount;
`else
    assign timeout_count = 16'h0000;
`endif

endmodule

// File: tb/tb_umi_resp_watchdog.sv
module tb_umi_resp_watchdog;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic          udev_req_valid;
    logic [CW-1:0] udev_req_cmd;
    logic [AW-1:0] udev_req_dstaddr;
    logic [AW-1:0] udev_req_srcaddr;
    logic [DW-1:0] udev_req_data;
    logic          udev_req_ready;
    logic          udev_resp_valid;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [AW-1:0] udev_resp_srcaddr;
    logic [DW-1:0] udev_resp_data;
    logic          udev_resp_ready;
    logic          uhost_req_valid;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr;
    logic [AW-1:0] uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_req_ready;
    logic          uhost_resp_valid;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr;
    logic [AW-1:0] uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;
    logic          uhost_resp_ready;
    logic          timeout_pulse;
    logic [15:0]   timeout_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    umi_resp_watchdog #(.DW(DW), .CW(CW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .nreset(nreset),
        .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
        .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
        .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
        .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
        .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
        .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready),
        .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        udev_req_valid     = 1'b0;
        udev_req_cmd       = $urandom;
        udev_req_dstaddr   = {$urandom, $urandom};
        udev_req_srcaddr   = {$urandom, $urandom};
        udev_req_data      = $urandom;
        uhost_req_ready    = 1'b1;
        udev_resp_ready    = 1'b1;
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = $urandom;
        uhost_resp_dstaddr = {$urandom, $urandom};
        uhost_resp_srcaddr = {$urandom, $urandom};
        uhost_resp_data    = $urandom;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        quiet();
        uhost_req_ready  = 1'b0;
        uhost_resp_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if ({udev_req_ready, uhost_req_valid, udev_resp_valid, uhost_resp_ready, timeout_pulse} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 00000", {udev_req_ready, uhost_req_valid, udev_resp_valid, uhost_resp_ready, timeout_pulse});
        end
        n_tests++;
        if (timeout_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", timeout_count);
        end
        nreset = 1'b1;
        uhost_req_ready = 1'b1;
        udev_req_valid  = 1'b1;
        settle();
        n_tests++;
        if ({udev_req_ready, uhost_req_valid, udev_resp_valid, uhost_resp_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_idle_pass got %b want 1100", {udev_req_ready, uhost_req_valid, udev_resp_valid, uhost_resp_ready});
        end
        quiet();
        tick();
    endtask

    // Non-posted read; each beat answered on cycle d after the previous
    // handshake (d <= TO). fixed_d = 0 picks d at random.
    task automatic test_read(input int beats, input int fixed_d);
        logic [CW-1:0] c;
        int d;
        quiet();
        c = $urandom;
        c[4:0] = 5'h01;
        udev_req_valid   = 1'b1;
        udev_req_cmd     = c;
        udev_req_dstaddr = 64'h100;
        settle();
        n_tests++;
        if ({uhost_req_valid, udev_req_ready, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data}
            !== {2'b11, c, 64'h100, udev_req_srcaddr, udev_req_data}) begin
            n_fail++;
            $display("FAIL read_req_fwd got cmd %h dst %h want cmd %h dst 100", uhost_req_cmd, uhost_req_dstaddr, c);
        end
        tick();
        for (int b = 0; b < beats; b++) begin
            d = (fixed_d > 0) ? fixed_d : $urandom_range(1, TO);
            for (int i = 1; i <= d; i++) begin
                udev_req_valid     = 1'b1;
                uhost_req_ready    = 1'b1;
                uhost_resp_cmd     = $urandom;
                uhost_resp_dstaddr = {$urandom, $urandom};
                uhost_resp_srcaddr = {$urandom, $urandom};
                uhost_resp_data    = $urandom;
                if (i == d) begin
                    uhost_resp_valid   = 1'b1;
                    udev_resp_ready    = 1'b1;
                    uhost_resp_cmd[22] = (b == beats - 1);
                end else begin
                    uhost_resp_valid = 1'($urandom_range(0, 1));
                    udev_resp_ready  = uhost_resp_valid ? 1'b0 : 1'($urandom_range(0, 1));
                end
                settle();
                n_tests++;
                if ({udev_resp_valid, uhost_resp_ready, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data}
                    !== {uhost_resp_valid, udev_resp_ready, uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data}) begin
                    n_fail++;
                    $display("FAIL read_resp_pass beat %0d cyc %0d got v%b r%b cmd %h want v%b r%b cmd %h", b, i,
                             udev_resp_valid, uhost_resp_ready, udev_resp_cmd, uhost_resp_valid, udev_resp_ready, uhost_resp_cmd);
                end
                n_tests++;
                if ({uhost_req_valid, udev_req_ready, timeout_pulse} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL read_wait_block beat %0d cyc %0d got %b want 000", b, i, {uhost_req_valid, udev_req_ready, timeout_pulse});
                end
                tick();
            end
        end
        quiet();
        uhost_resp_valid = 1'b1;
        settle();
        n_tests++;
        if ({udev_resp_valid, uhost_resp_ready, udev_req_ready, timeout_pulse} !== 4'b0010) begin
            n_fail++;
            $display("FAIL read_back_idle got %b want 0010", {udev_resp_valid, uhost_resp_ready, udev_req_ready, timeout_pulse});
        end
        quiet();
        tick();
    endtask

    task automatic test_back_to_back_posted();
        logic [CW-1:0] c;
        quiet();
        c = $urandom;
        c[4:0] = 5'h05;
        udev_req_valid = 1'b1;
        udev_req_cmd   = c;
        settle();
        n_tests++;
        if ({uhost_req_valid, udev_req_ready, uhost_req_cmd, uhost_req_dstaddr} !== {2'b11, c, udev_req_dstaddr}) begin
            n_fail++;
            $display("FAIL posted_fwd got v%b r%b cmd %h want 11 cmd %h", uhost_req_valid, udev_req_ready, uhost_req_cmd, c);
        end
        tick();
        c = $urandom;
        c[4:0] = 5'h05;
        udev_req_cmd     = c;
        udev_req_data    = $urandom;
        uhost_resp_valid = 1'b1;
        settle();
        n_tests++;
        if ({udev_req_ready, uhost_req_valid, uhost_resp_ready, udev_resp_valid, uhost_req_data}
            !== {4'b1100, udev_req_data}) begin
            n_fail++;
            $display("FAIL posted_b2b got %b data %h want 1100 data %h",
                     {udev_req_ready, uhost_req_valid, uhost_resp_ready, udev_resp_valid}, uhost_req_data, udev_req_data);
        end
        tick();
        quiet();
        uhost_resp_valid = 1'b1;
        settle();
        n_tests++;
        if ({udev_req_ready, uhost_resp_ready, udev_resp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL posted_idle got %b want 100", {udev_req_ready, uhost_resp_ready, udev_resp_valid});
        end
        quiet();
        tick();
    endtask

    // Unanswered request; core stalls the error `hold` cycles; a late eom
    // response appears `late` cycles into the drain (late < 0: none).
    task automatic test_timeout(input bit is_read, input int hold, input int late);
        logic [CW-1:0] c;
        logic [CW-1:0] exp_cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        int n;
        quiet();
        c = $urandom;
        c[4:0] = is_read ? 5'h01 : 5'h03;
        dst = is_read ? 64'hDEAD_0000 : {$urandom, $urandom};
        src = {$urandom, $urandom};
        udev_req_valid   = 1'b1;
        udev_req_cmd     = c;
        udev_req_dstaddr = dst;
        udev_req_srcaddr = src;
        exp_cmd        = '0;
        exp_cmd[4:0]   = is_read ? 5'h02 : 5'h04;
        exp_cmd[15:5]  = c[15:5];
        exp_cmd[22]    = 1'b1;
        exp_cmd[26:25] = 2'b10;
        exp_cmd[31:27] = c[31:27];
        settle();
        tick();
        udev_req_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            udev_resp_ready  = 1'($urandom_range(0, 1));
            uhost_resp_valid = 1'b0;
            settle();
            n_tests++;
            if ({udev_resp_valid, timeout_pulse} !== 2'b00) begin
                n_fail++;
                $display("FAIL to_wait cyc %0d got %b want 00", i, {udev_resp_valid, timeout_pulse});
            end
            tick();
        end
`ifdef UMI_WATCHDOG_COUNT_EN
        if (exp_count < 65535) exp_count++;
`endif
        for (int k = 0; k <= hold; k++) begin
            udev_resp_ready  = (k == hold);
            uhost_resp_valid = 1'($urandom_range(0, 1));
            settle();
            n_tests++;
            if ({udev_resp_valid, uhost_resp_ready, udev_req_ready} !== 3'b100) begin
                n_fail++;
                $display("FAIL to_err_ctl k %0d got %b want 100", k, {udev_resp_valid, uhost_resp_ready, udev_req_ready});
            end
            n_tests++;
            if ({udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data} !== {exp_cmd, src, dst, 32'h0}) begin
                n_fail++;
                $display("FAIL to_err_payload k %0d got cmd %h dst %h src %h data %h want cmd %h dst %h src %h data 0",
                         k, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data, exp_cmd, src, dst);
            end
            n_tests++;
            if (timeout_pulse !== (k == 0)) begin
                n_fail++;
                $display("FAIL to_pulse k %0d got %b want %b", k, timeout_pulse, (k == 0));
            end
            n_tests++;
            if (timeout_count !== 16'(exp_count)) begin
                n_fail++;
                $display("FAIL to_count got %0d want %0d", timeout_count, exp_count);
            end
            tick();
        end
        n = (late < 0) ? TO : late + 1;
        for (int d = 0; d < n; d++) begin
            udev_resp_ready = 1'b1;
            uhost_resp_cmd  = $urandom;
            if (d == late) begin
                uhost_resp_valid   = 1'b1;
                uhost_resp_cmd[22] = 1'b1;
            end else begin
                uhost_resp_valid   = 1'($urandom_range(0, 1));
                uhost_resp_cmd[22] = 1'b0;
            end
            settle();
            n_tests++;
            if ({udev_resp_valid, uhost_resp_ready, udev_req_ready, timeout_pulse} !== 4'b0100) begin
                n_fail++;
                $display("FAIL to_drain cyc %0d got %b want 0100", d, {udev_resp_valid, uhost_resp_ready, udev_req_ready, timeout_pulse});
            end
            tick();
        end
        quiet();
        settle();
        n_tests++;
        if ({udev_req_ready, uhost_resp_ready, udev_resp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL to_back_idle got %b want 100", {udev_req_ready, uhost_resp_ready, udev_resp_valid});
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        quiet();
        udev_req_valid = 1'b1;
        udev_req_cmd[4:0] = 5'h01;
        settle();
        tick();
        udev_req_valid = 1'b0;
        repeat ($urandom_range(1, TO - 2)) tick();
        #2;
        nreset = 1'b0;
        uhost_resp_valid = 1'b1;
        udev_resp_ready  = 1'b1;
        uhost_req_ready  = 1'b1;
        settle();
        exp_count = 0;
        n_tests++;
        if ({udev_resp_valid, uhost_resp_ready, timeout_pulse, udev_req_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_wait_ctl got %b want 0001", {udev_resp_valid, uhost_resp_ready, timeout_pulse, udev_req_ready});
        end
        n_tests++;
        if (timeout_count !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_wait_count got %0d want 0", timeout_count);
        end
        tick();
        tick();
        nreset = 1'b1;
        quiet();
        tick();
        test_read(1, 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_read(1, 3);
        for (int i = 0; i < 6; i++) test_read($urandom_range(1, 3), 0);
        test_read(1, TO);
        test_read(3, TO);
        test_back_to_back_posted();
        test_back_to_back_posted();
        test_timeout(1'b1, 0, -1);
        test_timeout(1'b0, $urandom_range(1, 4), $urandom_range(0, TO - 1));
        test_timeout(1'b1, 2, 0);
        test_timeout(1'b0, 0, -1);
        test_reset_in_wait();
        test_timeout(1'b1, 1, 5);
        test_read(2, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
